sdram_arb: RTL and testbench
============================

SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter TAGD, default 4: depth of the read-tag FIFO (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 c_req  input  [1:0]  per-client request valid.
REQ-005 c_we  input  [1:0]  per-client write (1) / read (0).
REQ-006 c_addr0, c_addr1  input  24 each  client word address.
REQ-007 c_data0, c_data1  input  16 each  client write data.
REQ-008 c_rdy  output  [1:0]  per-client accept; transfer = c_req[k] & c_rdy[k] at clk edge.
REQ-009 c_rvalid  output  [1:0]  one-cycle read-return strobe per client.
REQ-010 c_rdata  output  16  read-return data, shared by both clients.
REQ-011 m_req, m_we  output  1 each  downstream request and write flag.
REQ-012 m_addr, m_data  output  24, 16  downstream address and write data.
REQ-013 m_rdy  input  1  downstream accept; transfer = m_req & m_rdy.
REQ-014 m_rdata, m_rvalid  input  16, 1  downstream in-order read return.
REQ-015 err  output  1  sticky: m_rvalid seen with tag FIFO empty.

Function
REQ-016 Client k eligible = c_req[k] & (c_we[k] | ~tag_full).
REQ-017 Grant combinational: single eligible client wins; both eligible -> client selected by round-robin pointer rr.
REQ-018 m_req = eligible(grant); m_we/m_addr/m_data = granted client's fields, zero-latency pass-through.
REQ-019 c_rdy[grant] = m_rdy when eligible; the non-granted client's c_rdy = 0.
REQ-020 On transfer by client k, rr <= ~k; rr unchanged in cycles without transfer.
REQ-021 On read transfer, client index pushed into tag FIFO; count +1.
REQ-022 On m_rvalid with FIFO non-empty: head tag popped; c_rvalid[head] = 1 in the same cycle; c_rdata = m_rdata combinationally.
REQ-023 Simultaneous push and pop: both performed, count unchanged, pointers advance modulo TAGD.
REQ-024 tag_full (count == TAGD) blocks read push even if a pop occurs that cycle; writes still pass.
REQ-025 m_rvalid with FIFO empty: no c_rvalid, err <= 1, held until reset.
REQ-026 Read-pointer and write-pointer wrap from TAGD-1 to 0; count width log2(TAGD)+1.

Reset
REQ-027 On reset: rr = 0, tag FIFO empty (count, pointers = 0), err = 0; outputs m_req, c_rdy, c_rvalid = 0 in the reset cycle.
REQ-028 Reset asserted mid-operation discards all pending tags; returns arriving after reset raise err.

Configuration
REQ-029 Macro SDRAM_ARB_PRIO_EN defined: fixed priority, client 0 always wins when both eligible; rr is not used.
REQ-030 Macro undefined: round-robin per REQ-017/REQ-020.

Verification
REQ-031 Both clients read continuously, m_rdy=1 -> grants alternate 0,1,0,1; returns routed to issuing client in order.
REQ-032 Client 0 issues 4 reads (TAGD=4), no returns -> client 0's 5th read c_rdy=0; client 1 write accepted in the same cycle.
REQ-033 FIFO full, m_rvalid=1 and client read pending same cycle -> pop occurs, push refused; push accepted next cycle.
REQ-034 m_rvalid with empty FIFO -> err=1, c_rvalid=00; err stays 1 until reset.
REQ-035 SDRAM_ARB_PRIO_EN defined, both clients requesting 3 cycles -> client 0 granted all 3.
REQ-036 Reset after 2 reads issued -> count=0; next 2 m_rvalid pulses set err, c_rvalid stays 00.

Source files
------------

// File: rtl/sdram_arb.sv
// sdram_arb
// Two-client arbiter in front of a single SDRAM-style request port. It issues
// reads and writes downstream and routes in-order read returns back to the
// issuing client through a small tag FIFO.
//
// Optional feature macro: SDRAM_ARB_PRIO_EN
//   defined   -> fixed priority, client 0 wins when both clients are eligible
//   undefined -> round-robin between the two clients (default)
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   c_req, c_we           per-client request valid / write flag
//   c_addr0/1, c_data0/1  per-client word address and write data
//   c_rdy                 per-client accept (transfer = c_req & c_rdy)
//   c_rvalid, c_rdata     per-client read-return strobe, shared return data
//   m_req, m_we, m_addr, m_data   downstream request (zero-latency pass-through)
//   m_rdy                 downstream accept
//   m_rdata, m_rvalid     downstream in-order read return
//   err                   sticky: a return arrived with no outstanding read
module sdram_arb #(
  parameter int TAGD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  c_req,
  input  logic [1:0]  c_we,
  input  logic [23:0] c_addr0,
  input  logic [23:0] c_addr1,
  input  logic [15:0] c_data0,
  input  logic [15:0] c_data1,
  output logic [1:0]  c_rdy,
  output logic [1:0]  c_rvalid,
  output logic [15:0] c_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [23:0] m_addr,
  output logic [15:0] m_data,
  input  logic        m_rdy,
  input  logic [15:0] m_rdata,
  input  logic        m_rvalid,
  output logic        err
);

  localparam int PW = (TAGD > 1) ? $clog2(TAGD) : 1;
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          tag_mem [TAGD];

  logic [1:0] elig;
  logic       grant;
  logic       tag_full;
  logic       tag_empty;
  logic       push;
  logic       pop;
  logic       head;

`ifndef SDRAM_ARB_PRIO_EN
  logic       rr;
`endif

  assign tag_full  = (count == CW'(TAGD));
  assign tag_empty = (count == '0);

  always_comb begin
    // A read may only be granted while a tag slot is free; a pop in the same
    // cycle does not free the slot early.
    elig = c_req & (c_we | {2{~tag_full}});

`ifdef SDRAM_ARB_PRIO_EN
    grant = ~elig[0];
`else
    grant = (elig == 2'b11) ? rr : elig[1];
`endif

    m_req  = elig[grant] & ~reset;
    m_we   = c_we[grant];
    m_addr = grant ? c_addr1 : c_addr0;
    m_data = grant ? c_data1 : c_data0;

    c_rdy        = 2'b00;
    c_rdy[grant] = m_req & m_rdy;

    push = m_req & m_rdy & ~c_we[grant];
    pop  = m_rvalid & ~tag_empty & ~reset;

    head           = tag_mem[rptr];
    c_rvalid       = 2'b00;
    c_rvalid[head] = pop;
    c_rdata        = m_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      err   <= 1'b0;
`ifndef SDRAM_ARB_PRIO_EN
      rr    <= 1'b0;
`endif
    end else begin
      if (push) wptr <= (wptr == PW'(TAGD - 1)) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PW'(TAGD - 1)) ? '0 : rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (m_rvalid && tag_empty) err <= 1'b1;
`ifndef SDRAM_ARB_PRIO_EN
      if (m_req && m_rdy) rr <= ~grant;
`endif
    end
  end

  // Tag storage holds only the issuing client index; no reset needed.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wptr] <= grant;
  end

endmodule

// File: tb/tb_sdram_arb.sv
module tb_sdram_arb;

  logic        clk;
  logic        reset;
  logic [1:0]  c_req;
  logic [1:0]  c_we;
  logic [23:0] c_addr0;
  logic [23:0] c_addr1;
  logic [15:0] c_data0;
  logic [15:0] c_data1;
  logic [1:0]  c_rdy;
  logic [1:0]  c_rvalid;
  logic [15:0] c_rdata;
  logic        m_req;
  logic        m_we;
  logic [23:0] m_addr;
  logic [15:0] m_data;
  logic        m_rdy;
  logic [15:0] m_rdata;
  logic        m_rvalid;
  logic        err;

  int errors;
  int checks;

  sdram_arb #(.TAGD(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we),
    .c_addr0(c_addr0), .c_addr1(c_addr1),
    .c_data0(c_data0), .c_data1(c_data1),
    .c_rdy(c_rdy), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_data(m_data),
    .m_rdy(m_rdy), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic rdy,
                       input logic rv, input logic [15:0] rd);
    c_req    = req;
    c_we     = we;
    m_rdy    = rdy;
    m_rvalid = rv;
    m_rdata  = rd;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    c_addr0 = 24'h000100;
    c_addr1 = 24'h000200;
    c_data0 = 16'h1111;
    c_data1 = 16'h2222;
    reset   = 1'b1;

    // Reset cycle: outputs forced low even with live requests and a return
    drive(2'b11, 2'b00, 1'b1, 1'b1, 16'hdead);
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_c_rdy", c_rdy, 2'b00);
    chk("rst_c_rvalid", c_rvalid, 2'b00);
    tick;
    reset = 1'b0;
    chk("rst_err", err, 1'b0);

    // Both clients read continuously: grants alternate 0,1,0,1
    drive(2'b11, 2'b00, 1'b1, 1'b0, 16'h0);
    chk("rr0_c_rdy", c_rdy, 2'b01);
    chk("rr0_m_addr", m_addr, 24'h000100);
    chk("rr0_m_we", m_we, 1'b0);
    tick;
    chk("rr1_c_rdy", c_rdy, 2'b10);
    chk("rr1_m_addr", m_addr, 24'h000200);
    tick;
    chk("rr2_c_rdy", c_rdy, 2'b01);
    tick;
    chk("rr3_c_rdy", c_rdy, 2'b10);
    tick;
    // FIFO now full: reads blocked
    chk("full_m_req", m_req, 1'b0);
    chk("full_c_rdy", c_rdy, 2'b00);

    // Returns routed in issue order 0,1,0,1
    drive(2'b00, 2'b00, 1'b1, 1'b1, 16'ha001);
    chk("ret0_c_rvalid", c_rvalid, 2'b01);
    chk("ret0_c_rdata", c_rdata, 16'ha001);
    tick;
    drive(2'b00, 2'b00, 1'b1, 1'b1, 16'ha002);
    chk("ret1_c_rvalid", c_rvalid, 2'b10);
    chk("ret1_c_rdata", c_rdata, 16'ha002);
    tick;
    drive(2'b00, 2'b00, 1'b1, 1'b1, 16'ha003);
    chk("ret2_c_rvalid", c_rvalid, 2'b01);
    tick;
    drive(2'b00, 2'b00, 1'b1, 1'b1, 16'ha004);
    chk("ret3_c_rvalid", c_rvalid, 2'b10);
    tick;

    // Client 0 issues four reads, fifth blocked; client 1 write still passes
    drive(2'b01, 2'b00, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("c0rd%0d_c_rdy", i), c_rdy, 2'b01);
      tick;
    end
    drive(2'b11, 2'b10, 1'b1, 1'b0, 16'h0);
    chk("blk_c_rdy", c_rdy, 2'b10);
    chk("blk_m_we", m_we, 1'b1);
    chk("blk_m_addr", m_addr, 24'h000200);
    chk("blk_m_data", m_data, 16'h2222);
    tick;

    // Downstream stall: request presented but nobody accepted
    drive(2'b10, 2'b10, 1'b0, 1'b0, 16'h0);
    chk("stall_m_req", m_req, 1'b1);
    chk("stall_c_rdy", c_rdy, 2'b00);
    tick;

    // Full + return + pending read: pop happens, push refused this cycle
    drive(2'b01, 2'b00, 1'b1, 1'b1, 16'hb000);
    chk("fp_c_rvalid", c_rvalid, 2'b01);
    chk("fp_c_rdy", c_rdy, 2'b00);
    chk("fp_m_req", m_req, 1'b0);
    tick;
    drive(2'b01, 2'b00, 1'b1, 1'b0, 16'h0);
    chk("fp_next_c_rdy", c_rdy, 2'b01);
    tick;

    // Drain the four outstanding client-0 reads
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 2'b00, 1'b1, 1'b1, 16'hc000 + 16'(i));
      chk($sformatf("drain%0d_c_rvalid", i), c_rvalid, 2'b01);
      chk($sformatf("drain%0d_c_rdata", i), c_rdata, 16'hc000 + 16'(i));
      tick;
    end

    // Return with empty FIFO: err set and sticky
    drive(2'b00, 2'b00, 1'b1, 1'b1, 16'he000);
    chk("empty_c_rvalid", c_rvalid, 2'b00);
    tick;
    drive(2'b00, 2'b00, 1'b1, 1'b0, 16'h0);
    chk("empty_err", err, 1'b1);
    tick;
    tick;
    chk("err_sticky", err, 1'b1);

    // Reset after two reads discards the tags
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst2_err", err, 1'b0);
    drive(2'b01, 2'b00, 1'b1, 1'b0, 16'h0);
    tick;
    tick;
    drive(2'b00, 2'b00, 1'b1, 1'b0, 16'h0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst3_count", dut.count, 0);
    drive(2'b00, 2'b00, 1'b1, 1'b1, 16'hf001);
    chk("post_rst_rv0", c_rvalid, 2'b00);
    tick;
    chk("post_rst_err0", err, 1'b1);
    drive(2'b00, 2'b00, 1'b1, 1'b1, 16'hf002);
    chk("post_rst_rv1", c_rvalid, 2'b00);
    tick;
    chk("post_rst_err1", err, 1'b1);

    // Both clients writing for three cycles from a fresh reset
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drive(2'b11, 2'b11, 1'b1, 1'b0, 16'h0);
`ifdef SDRAM_ARB_PRIO_EN
    chk("prio0_c_rdy", c_rdy, 2'b01);
    tick;
    chk("prio1_c_rdy", c_rdy, 2'b01);
    tick;
    chk("prio2_c_rdy", c_rdy, 2'b01);
`else
    chk("wr0_c_rdy", c_rdy, 2'b01);
    tick;
    chk("wr1_c_rdy", c_rdy, 2'b10);
    tick;
    chk("wr2_c_rdy", c_rdy, 2'b01);
`endif
    tick;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
